edge_stream_feeder: RTL and testbench
=====================================

# edge_stream_feeder

Fetches a partition's edge list from external memory as 512-bit words and streams them into the BFS pipeline array. Each output word is tagged with its valid-edge count and a last-word marker, and carries the phase control code. Sits directly upstream of the BFS processing block, whose edge input has no backpressure, so the feeder buffers memory responses in an internal FIFO. It uses credit-limited read issue so the FIFO can never overflow.

## Interface
- FIFO_AW, 3: log2 of FIFO depth in 512-bit words (depth 8)
- EDGES_PER_WORD, 16: 32-bit edges per 512-bit word (fixed, not retuned)

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on a clk edge)
- start  in  1  one-cycle pulse; latches base_addr, num_edges, control_in; ignored while busy
- base_addr  in  32  byte address of first edge word, 64-byte aligned
- num_edges  in  32  edges in partition
- control_in  in  2  phase code forwarded on control_out
- mem_req_addr  out  32  read address
- mem_req_valid  out  1  read request valid; held with stable address until accepted
- mem_req_ready  in  1  request accepted when valid&&ready
- mem_rsp_data  in  512  read data; responses in request order
- mem_rsp_valid  in  1  data valid; always accepted, no ready
- word_out  out  512  edge word to BFS word_in
- word_out_valid  out  1  to BFS word_in_valid
- word_out_th  out  32  valid edges in word_out, to BFS word_in_th
- last_out  out  1  final output of the partition, to BFS last_input_in
- control_out  out  2  latched phase code, to BFS control
- busy  out  1  high from start acceptance until the cycle after last_out

## Operation
- num_words = ceil(num_edges/16), computed at start into a 28-bit register; th of last word = num_edges - 16*(num_words-1), range 1..16.
- FSM states:
  - IDLE: busy=0. Accepts start. Goes to FETCH if num_edges>0, else to FINISH.
  - FETCH: issues requests. mem_req_addr = base_addr + 64*req_idx. Goes to DRAIN when req_idx==num_words after the final accepted request.
  - DRAIN: no requests. Goes to FINISH after the final word is popped.
  - FINISH: one cycle, then IDLE.
- Credit rule: a request may be asserted only when outstanding + fifo_count < 2^FIFO_AW. outstanding increments on request acceptance and decrements on response. Simultaneous increment and decrement leave it unchanged.
- FIFO push on mem_rsp_valid. FIFO pops whenever it is non-empty, one word per cycle, into the output register.
- Last word: 32-bit lanes at index >= th are forced to zero. Lane 0 is bits [31:0].
- last_out is high with the final word's word_out_valid.
- num_edges==0 partition: FINISH drives last_out=1, word_out_valid=0, word_out_th=0 for one cycle.
- control_out holds the latched value until the next accepted start.
- Response with outstanding==0 is a protocol error: ignored, not pushed.
- Reset mid-operation: all state, the FIFO and the counters clear. In-flight responses arriving after reset are dropped by the outstanding==0 rule.

## Timing
- Reset values:
  - 0: mem_req_valid, word_out_valid, last_out, busy, word_out, word_out_th, control_out
  - 0: mem_req_addr
- start at cycle T → busy=1 and first mem_req_valid at T+1.
- Response accepted at cycle N into an empty FIFO → word_out_valid at N+1. The FIFO is read combinationally from head into the output register.
- Sustained throughput: 1 word/cycle when memory returns 1 response/cycle.
- busy falls the cycle after last_out.
- A new start is accepted at the earliest in the cycle busy is 0.

## Test plan
- num_edges=40, base_addr=0x1000, memory returns data 1 cycle after request.
  - Requests to 0x1000, 0x1040, 0x1080.
  - 3 output words with th=16,16,8.
  - Third word has lanes 8..15 zero and last_out=1.
  - busy drops the next cycle.
- num_edges=0, control_in=2 → one cycle of last_out=1, word_out_valid=0, control_out=2; no memory requests.
- num_edges=256 (16 words), mem_req_ready high, response latency 20 cycles:
  - outstanding+fifo_count never exceeds 8.
  - mem_req_valid stalls after 8 requests.
  - All 16 words emitted in order with th=16.
- mem_req_ready toggled 0/1 every cycle → mem_req_addr stable while valid&&!ready; no skipped or duplicate addresses.
- Reset asserted (rst=0) mid-FETCH with 3 responses in flight, then released:
  - All outputs return to reset values.
  - The late responses produce no word_out_valid.
  - A subsequent start with num_edges=16 yields exactly one word with th=16 and last_out=1.
- start pulsed while busy with different num_edges → ignored; the original partition completes unchanged.

Source files
------------

// File: rtl/edge_stream_feeder_if.sv
// -----------------------------------------------------------------------------
// edge_stream_feeder_if
//   Bundles everything the edge feeder exchanges with its neighbours:
//   - command side : start, base_addr, num_edges, control_in, busy
//   - memory side  : mem_req_addr/valid/ready, mem_rsp_data/valid
//   - BFS side     : word_out, word_out_valid, word_out_th, last_out, control_out
//   master : the feeder itself (drives requests, the output stream and busy)
//   slave  : the environment (command source, memory, BFS consumer)
// -----------------------------------------------------------------------------
interface edge_stream_feeder_if;
    logic         start;
    logic [31:0]  base_addr;
    logic [31:0]  num_edges;
    logic [1:0]   control_in;
    logic         busy;

    logic [31:0]  mem_req_addr;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [511:0] mem_rsp_data;
    logic         mem_rsp_valid;

    logic [511:0] word_out;
    logic         word_out_valid;
    logic [31:0]  word_out_th;
    logic         last_out;
    logic [1:0]   control_out;

    modport master (
        input  start, base_addr, num_edges, control_in,
        input  mem_req_ready, mem_rsp_data, mem_rsp_valid,
        output busy, mem_req_addr, mem_req_valid,
        output word_out, word_out_valid, word_out_th, last_out, control_out
    );

    modport slave (
        output start, base_addr, num_edges, control_in,
        output mem_req_ready, mem_rsp_data, mem_rsp_valid,
        input  busy, mem_req_addr, mem_req_valid,
        input  word_out, word_out_valid, word_out_th, last_out, control_out
    );
endinterface

// File: rtl/edge_stream_feeder.sv
// -----------------------------------------------------------------------------
// edge_stream_feeder
//   Reads one partition's edge list from memory as 512-bit words and streams
//   them to the BFS array. Each output word carries its valid-edge count and a
//   last marker; lanes beyond the count in the final word are zeroed.
//   Read issue is credit limited (outstanding + FIFO occupancy < depth) so the
//   response FIFO can never overflow, since the BFS side cannot stall us.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-low reset
//     bus  - edge_stream_feeder_if.master (command, memory and BFS signals)
// -----------------------------------------------------------------------------
module edge_stream_feeder #(
    parameter int FIFO_AW        = 3,
    parameter int EDGES_PER_WORD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    edge_stream_feeder_if.master bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef logic [CW-1:0]      cnt_t;
    typedef logic [FIFO_AW-1:0] ptr_t;

    localparam cnt_t          CNT_ZERO     = cnt_t'(0);
    localparam cnt_t          CNT_ONE      = cnt_t'(1);
    localparam ptr_t          PTR_ONE      = ptr_t'(1);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
    localparam logic [4:0]    FULL_TH      = 5'(EDGES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Zero every 32-bit lane whose index is at or above the edge count.
    function automatic logic [511:0] mask_lanes(input logic [511:0] w, input logic [4:0] th);
        logic [511:0] m;
        m = w;
        for (int i = 0; i < EDGES_PER_WORD; i++) begin
            if (5'(i) >= th) begin
                m[i*32 +: 32] = 32'd0;
            end else begin
                m[i*32 +: 32] = w[i*32 +: 32];
            end
        end
        return m;
    endfunction

    // Registered state
    state_t       state_q;
    logic [31:0]  base_q;
    logic [27:0]  num_words_q;
    logic [4:0]   last_th_q;
    logic [27:0]  req_idx_q;
    logic [27:0]  out_idx_q;
    cnt_t         outstanding_q;
    cnt_t         count_q;
    ptr_t         wr_ptr_q;
    ptr_t         rd_ptr_q;
    logic         req_valid_q;
    logic [31:0]  req_addr_q;
    logic [511:0] word_q;
    logic         word_valid_q;
    logic [4:0]   th_q;
    logic         last_q;
    logic [1:0]   ctrl_q;
    logic         busy_q;
    logic [511:0] fifo_mem_q [DEPTH];

    // Combinational next-state and datapath signals
    logic         req_fire_s;
    logic         rsp_ok_s;
    logic         fifo_nonempty_s;
    logic         push_s;
    logic         pop_s;
    logic         bypass_s;
    logic         out_fire_s;
    logic [511:0] out_data_s;
    logic         is_last_s;
    logic [4:0]   out_th_s;
    logic [511:0] word_d;
    cnt_t         outstanding_d;
    cnt_t         count_d;
    ptr_t         wr_ptr_d;
    ptr_t         rd_ptr_d;
    logic [27:0]  req_idx_d;
    logic [CW:0]  credit_sum_s;
    logic         req_valid_d;
    logic [31:0]  req_addr_d;
    logic [27:0]  start_num_words_s;
    logic [4:0]   start_last_th_s;

    // Handshakes, credit accounting, FIFO pointers and output word selection.
    always_comb begin
        req_fire_s      = req_valid_q & bus.mem_req_ready;
        // A response with nothing outstanding is stale (e.g. from before a reset).
        rsp_ok_s        = bus.mem_rsp_valid & (outstanding_q != CNT_ZERO);
        fifo_nonempty_s = (count_q != CNT_ZERO);
        // With an empty FIFO the response goes straight to the output register,
        // otherwise it queues behind the head word popped this cycle.
        push_s          = rsp_ok_s & fifo_nonempty_s;
        pop_s           = fifo_nonempty_s;
        bypass_s        = rsp_ok_s & ~fifo_nonempty_s;
        out_fire_s      = pop_s | bypass_s;
        if (fifo_nonempty_s) begin
            out_data_s = fifo_mem_q[rd_ptr_q];
        end else begin
            out_data_s = bus.mem_rsp_data;
        end
        is_last_s = (out_idx_q == (num_words_q - 28'd1));
        if (is_last_s) begin
            out_th_s = last_th_q;
        end else begin
            out_th_s = FULL_TH;
        end
        word_d = mask_lanes(out_data_s, out_th_s);

        case ({req_fire_s, rsp_ok_s})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (req_fire_s) begin
            req_idx_d = req_idx_q + 28'd1;
        end else begin
            req_idx_d = req_idx_q;
        end
        // Credit is evaluated on next-cycle values so a registered request is
        // only raised when it already fits in the FIFO budget.
        credit_sum_s = {1'b0, outstanding_d} + {1'b0, count_d};
        req_valid_d  = (req_idx_d < num_words_q) && (credit_sum_s < CREDIT_LIMIT);
        req_addr_d   = base_q + {req_idx_d[25:0], 6'd0};

        start_num_words_s = bus.num_edges[31:4] + {27'd0, |bus.num_edges[3:0]};
        if (bus.num_edges[3:0] == 4'd0) begin
            start_last_th_s = FULL_TH;
        end else begin
            start_last_th_s = {1'b0, bus.num_edges[3:0]};
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= bus.mem_rsp_data;
        end
    end

    // Control FSM, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            base_q        <= 32'd0;
            num_words_q   <= 28'd0;
            last_th_q     <= 5'd0;
            req_idx_q     <= 28'd0;
            out_idx_q     <= 28'd0;
            outstanding_q <= CNT_ZERO;
            count_q       <= CNT_ZERO;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= 32'd0;
            word_q        <= 512'd0;
            word_valid_q  <= 1'b0;
            th_q          <= 5'd0;
            last_q        <= 1'b0;
            ctrl_q        <= 2'd0;
            busy_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            req_idx_q     <= req_idx_d;
            word_valid_q  <= out_fire_s;
            last_q        <= out_fire_s & is_last_s;
            if (out_fire_s) begin
                word_q    <= word_d;
                th_q      <= out_th_s;
                out_idx_q <= out_idx_q + 28'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    req_valid_q <= 1'b0;
                    if (bus.start) begin
                        base_q      <= bus.base_addr;
                        num_words_q <= start_num_words_s;
                        last_th_q   <= start_last_th_s;
                        ctrl_q      <= bus.control_in;
                        req_idx_q   <= 28'd0;
                        out_idx_q   <= 28'd0;
                        busy_q      <= 1'b1;
                        if (bus.num_edges != 32'd0) begin
                            state_q     <= ST_FETCH;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= bus.base_addr;
                        end else begin
                            // Empty partition: a bare last marker with no data.
                            state_q <= ST_FINISH;
                            last_q  <= 1'b1;
                            th_q    <= 5'd0;
                        end
                    end
                end
                ST_FETCH: begin
                    req_valid_q <= req_valid_d;
                    req_addr_q  <= req_addr_d;
                    if (out_fire_s && is_last_s) begin
                        state_q <= ST_FINISH;
                    end else if (req_fire_s && (req_idx_d == num_words_q)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    req_valid_q <= 1'b0;
                    if (out_fire_s && is_last_s) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_addr   = req_addr_q;
    assign bus.mem_req_valid  = req_valid_q;
    assign bus.word_out       = word_q;
    assign bus.word_out_valid = word_valid_q;
    assign bus.word_out_th    = {27'd0, th_q};
    assign bus.last_out       = last_q;
    assign bus.control_out    = ctrl_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_edge_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_edge_stream_feeder
//   Directed bench for edge_stream_feeder. A memory model answers requests
//   after a programmable latency; a scoreboard receives the expected output
//   words when a start is issued and is drained as the DUT emits words.
// -----------------------------------------------------------------------------
module tb_edge_stream_feeder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    edge_stream_feeder_if bus ();

    edge_stream_feeder #(.FIFO_AW(3), .EDGES_PER_WORD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [511:0] data;
        logic [31:0]  th;
        logic         last;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    exp_t        sb[$];
    req_t        memq[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          lat;
    int          ready_mode;
    int          acc_total;
    int          acc_limit;
    int          words_total;
    int          pending;
    logic [31:0] exp_base;
    int          exp_idx;
    bit          stall_prev;
    logic [31:0] prev_addr;
    bit          start_expected;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] gen_lane(input logic [31:0] a, input int i);
        return {a[15:0], 8'hA5, 8'(i)};
    endfunction

    function automatic logic [511:0] gen_word(input logic [31:0] a);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = gen_lane(a, i);
        return w;
    endfunction

    function automatic logic [511:0] exp_word(input logic [31:0] a, input int th);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = (i < th) ? gen_lane(a, i) : 32'd0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Memory model plus output monitor, evaluated at every falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.mem_req_ready = 1'b1;
                1:       bus.mem_req_ready = ~bus.mem_req_ready;
                default: bus.mem_req_ready = (acc_total < acc_limit);
            endcase
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = gen_word(memq[0].addr);
                void'(memq.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = {16{32'hDEADBEEF}};
            end
            if (!rst) begin
                sb.delete();
                pending    = 0;
                stall_prev = 1'b0;
            end else begin
                if (bus.start && start_expected) begin
                    int n, nw;
                    n  = int'(bus.num_edges);
                    nw = (n + 15) / 16;
                    exp_base = bus.base_addr;
                    exp_idx  = 0;
                    for (int w = 0; w < nw; w++) begin
                        e.th   = (w == nw - 1) ? 32'(n - 16 * (nw - 1)) : 32'd16;
                        e.data = exp_word(bus.base_addr + 32'(64 * w), int'(e.th));
                        e.last = (w == nw - 1);
                        sb.push_back(e);
                    end
                end
                if (bus.word_out_valid) begin
                    words_total++;
                    pending--;
                    if (sb.size() == 0) begin
                        chk("spurious_word", 512'(bus.word_out_valid), 512'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", bus.word_out, e.data);
                        chk("word_th", 512'(bus.word_out_th), 512'(e.th));
                        chk("word_last", 512'(bus.last_out), 512'(e.last));
                    end
                end
                if (stall_prev) begin
                    chk("req_hold_valid", 512'(bus.mem_req_valid), 512'(1'b1));
                    chk("req_hold_addr", 512'(bus.mem_req_addr), 512'(prev_addr));
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    chk("req_addr", 512'(bus.mem_req_addr), 512'(exp_base + 32'(64 * exp_idx)));
                    chk("credit", 512'(pending < 8), 512'(1'b1));
                    exp_idx++;
                    pending++;
                    acc_total++;
                    memq.push_back('{bus.mem_req_addr, cyc + lat});
                end
                stall_prev = bus.mem_req_valid && !bus.mem_req_ready;
                prev_addr  = bus.mem_req_addr;
            end
        end
    endtask

    task automatic launch(input logic [31:0] n, input logic [31:0] base,
                          input logic [1:0] ctrl, input bit expect_acc);
        step();
        start_expected = expect_acc;
        bus.start      = 1'b1;
        bus.num_edges  = n;
        bus.base_addr  = base;
        bus.control_in = ctrl;
        step();
        bus.start      = 1'b0;
        start_expected = 1'b0;
    endtask

    task automatic wait_last(input int maxc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            sample();
            seen = bus.last_out;
        end
        chk({tag, "_last_seen"}, 512'(seen), 512'(1'b1));
    endtask

    initial begin
        int acc0, words0;
        bit reached;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = 32'd0;
        bus.num_edges  = 32'd0;
        bus.control_in = 2'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 512'd0;
        lat = 1; ready_mode = 0; acc_total = 0; acc_limit = 0;
        words_total = 0; pending = 0; exp_base = 32'd0; exp_idx = 0;
        stall_prev = 1'b0; prev_addr = 32'd0; start_expected = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) step();
        sample();
        chk("rst_req_valid", 512'(bus.mem_req_valid), 512'(1'b0));
        chk("rst_req_addr", 512'(bus.mem_req_addr), 512'(32'd0));
        chk("rst_word_valid", 512'(bus.word_out_valid), 512'(1'b0));
        chk("rst_last", 512'(bus.last_out), 512'(1'b0));
        chk("rst_busy", 512'(bus.busy), 512'(1'b0));
        chk("rst_word", bus.word_out, 512'd0);
        chk("rst_th", 512'(bus.word_out_th), 512'(32'd0));
        chk("rst_ctrl", 512'(bus.control_out), 512'(2'd0));
        step();
        rst = 1'b1;

        // 40 edges, latency 1: three words, th 16/16/8
        lat = 1; ready_mode = 0; acc0 = acc_total;
        launch(32'd40, 32'h1000, 2'd1, 1'b1);
        sample();
        chk("A_busy_t1", 512'(bus.busy), 512'(1'b1));
        chk("A_req_valid_t1", 512'(bus.mem_req_valid), 512'(1'b1));
        chk("A_req_addr_t1", 512'(bus.mem_req_addr), 512'(32'h1000));
        chk("A_ctrl", 512'(bus.control_out), 512'(2'd1));
        sample();
        chk("A_no_word_t2", 512'(bus.word_out_valid), 512'(1'b0));
        sample();
        chk("A_word_t3", 512'(bus.word_out_valid), 512'(1'b1));
        wait_last(10, "A");
        chk("A_last_th", 512'(bus.word_out_th), 512'(32'd8));
        chk("A_busy_at_last", 512'(bus.busy), 512'(1'b1));
        sample();
        chk("A_busy_after", 512'(bus.busy), 512'(1'b0));
        chk("A_last_after", 512'(bus.last_out), 512'(1'b0));
        chk("A_sb_empty", 512'(sb.size()), 512'(0));
        chk("A_req_count", 512'(acc_total - acc0), 512'(3));

        // Empty partition
        acc0 = acc_total;
        launch(32'd0, 32'h2000, 2'd2, 1'b1);
        sample();
        chk("Z_last", 512'(bus.last_out), 512'(1'b1));
        chk("Z_word_valid", 512'(bus.word_out_valid), 512'(1'b0));
        chk("Z_th", 512'(bus.word_out_th), 512'(32'd0));
        chk("Z_ctrl", 512'(bus.control_out), 512'(2'd2));
        chk("Z_busy", 512'(bus.busy), 512'(1'b1));
        chk("Z_req_valid", 512'(bus.mem_req_valid), 512'(1'b0));
        sample();
        chk("Z_busy_after", 512'(bus.busy), 512'(1'b0));
        chk("Z_last_after", 512'(bus.last_out), 512'(1'b0));
        chk("Z_req_count", 512'(acc_total - acc0), 512'(0));

        // 256 edges, latency 20: credit stall after 8 requests
        lat = 20; acc0 = acc_total;
        launch(32'd256, 32'h0002_0000, 2'd0, 1'b1);
        reached = 1'b0;
        for (int k = 0; k < 30 && !reached; k++) begin
            sample();
            reached = (acc_total - acc0 == 8);
        end
        chk("C_eight_reqs", 512'(reached), 512'(1'b1));
        sample();
        chk("C_stall", 512'(bus.mem_req_valid), 512'(1'b0));
        chk("C_stall_count", 512'(acc_total - acc0), 512'(8));
        wait_last(200, "C");
        sample();
        chk("C_busy_after", 512'(bus.busy), 512'(1'b0));
        chk("C_sb_empty", 512'(sb.size()), 512'(0));
        chk("C_req_count", 512'(acc_total - acc0), 512'(16));

        // 100 edges with mem_req_ready toggling every cycle
        lat = 3; ready_mode = 1; acc0 = acc_total;
        launch(32'd100, 32'h0003_0000, 2'd3, 1'b1);
        wait_last(100, "D");
        chk("D_last_th", 512'(bus.word_out_th), 512'(32'd4));
        sample();
        chk("D_busy_after", 512'(bus.busy), 512'(1'b0));
        chk("D_sb_empty", 512'(sb.size()), 512'(0));
        chk("D_req_count", 512'(acc_total - acc0), 512'(7));
        ready_mode = 0;

        // Reset in FETCH with three responses in flight
        lat = 10; acc0 = acc_total; acc_limit = acc_total + 3; ready_mode = 2;
        launch(32'd160, 32'h6000, 2'd1, 1'b1);
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            sample();
            reached = (acc_total - acc0 == 3);
        end
        chk("E_three_reqs", 512'(reached), 512'(1'b1));
        step();
        rst = 1'b0;
        step();
        sample();
        chk("E_rst_req_valid", 512'(bus.mem_req_valid), 512'(1'b0));
        chk("E_rst_req_addr", 512'(bus.mem_req_addr), 512'(32'd0));
        chk("E_rst_word_valid", 512'(bus.word_out_valid), 512'(1'b0));
        chk("E_rst_last", 512'(bus.last_out), 512'(1'b0));
        chk("E_rst_busy", 512'(bus.busy), 512'(1'b0));
        chk("E_rst_word", bus.word_out, 512'd0);
        chk("E_rst_th", 512'(bus.word_out_th), 512'(32'd0));
        chk("E_rst_ctrl", 512'(bus.control_out), 512'(2'd0));
        words0 = words_total;
        ready_mode = 0;
        step();
        rst = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            sample();
            reached = (memq.size() == 0);
        end
        sample();
        sample();
        chk("E_late_drained", 512'(reached), 512'(1'b1));
        chk("E_no_late_words", 512'(words_total - words0), 512'(0));
        chk("E_idle_after_late", 512'(bus.busy), 512'(1'b0));
        lat = 1;
        launch(32'd16, 32'h4000, 2'd0, 1'b1);
        wait_last(20, "E2");
        chk("E2_th", 512'(bus.word_out_th), 512'(32'd16));
        sample();
        chk("E2_busy_after", 512'(bus.busy), 512'(1'b0));
        chk("E2_one_word", 512'(words_total - words0), 512'(1));
        chk("E2_sb_empty", 512'(sb.size()), 512'(0));

        // Start pulsed while busy is ignored
        lat = 5; acc0 = acc_total;
        launch(32'd48, 32'h8000, 2'd1, 1'b1);
        sample();
        sample();
        launch(32'd320, 32'h9000, 2'd3, 1'b0);
        wait_last(60, "F");
        chk("F_ctrl_kept", 512'(bus.control_out), 512'(2'd1));
        sample();
        chk("F_busy_after", 512'(bus.busy), 512'(1'b0));
        repeat (3) sample();
        chk("F_no_more_req", 512'(bus.mem_req_valid), 512'(1'b0));
        chk("F_req_count", 512'(acc_total - acc0), 512'(3));
        chk("F_sb_empty", 512'(sb.size()), 512'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
